// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Y86-64 SEQ fetch stage: PC register, byte imem, field split, status FSM.
module fetch_stage #(
    parameter int          IMEM_BYTES = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_wdata,
    input  logic              pc_load,
    input  logic [63:0]       new_pc,
    output logic [63:0]       pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [63:0]       valP,
    output logic              instr_valid,
    output logic [1:0]        stat,
    output logic [31:0]       icount
);

    typedef enum logic [1:0] {
        AOK = 2'b00,
        HLT = 2'b01,
        ADR = 2'b10,
        INS = 2'b11
    } stat_t;

    logic [7:0]  imem [IMEM_BYTES];
    logic [63:0] pc_q;
    stat_t       stat_q;
    logic [31:0] icount_q;

    logic [64:0] byte_addr [10];
    logic [7:0]  ib [10];
    logic [3:0]  len;
    logic        has_reg;
    logic        illegal;
    logic [64:0] last_addr;
    logic        addr_ok;

    // Program load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // 65-bit addresses so pc near 2^64 cannot wrap back into imem.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = {1'b0, pc_q} + 65'(i);
            ib[i]        = (byte_addr[i] < 65'(IMEM_BYTES)) ? imem[byte_addr[i][ADDR_W-1:0]] : 8'h00;
        end
    end

    assign icode = ib[0][7:4];
    assign ifun  = ib[0][3:0];

    always_comb begin
        len     = 4'd1;
        has_reg = 1'b0;
        illegal = 1'b0;
        valC    = 64'h0;
        case (icode)
            4'h0, 4'h1, 4'h9: len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            4'h3, 4'h4, 4'h5: begin
                len     = 4'd10;
                has_reg = 1'b1;
                valC    = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            end
            4'h7, 4'h8: begin
                len  = 4'd9;
                valC = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rA          = has_reg ? ib[1][7:4] : 4'hF;
    assign rB          = has_reg ? ib[1][3:0] : 4'hF;
    assign valP        = pc_q + 64'(len);
    assign last_addr   = {1'b0, pc_q} + 65'(len) - 65'd1;
    assign addr_ok     = last_addr < 65'(IMEM_BYTES);
    assign instr_valid = addr_ok && !illegal;

    // Commit only while AOK; ADR/INS/HLT are sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            stat_q   <= AOK;
            icount_q <= 32'd0;
        end else if (pc_load && stat_q == AOK) begin
            if (!addr_ok) begin
                stat_q <= ADR;
            end else if (illegal) begin
                stat_q <= INS;
            end else if (icode == 4'h0) begin
                stat_q <= HLT;
            end else begin
                pc_q     <= new_pc;
                icount_q <= icount_q + 32'd1;
            end
        end
    end

    assign pc     = pc_q;
    assign stat   = stat_q;
    assign icount = icount_q;

endmodule
